// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared owner/state encodings for the memory request arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {OWN_IC = 2'd0, OWN_DR = 2'd1, OWN_DW = 2'd2} owner_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR} state_t;
  localparam int STARVE_W = 4;
endpackage

// File: rtl/mem_arb_slot.sv
// mem_arb_slot: 1-deep request holding register with capture, free and overflow detect
module mem_arb_slot #(
  parameter int AWIDTH = 32,
  parameter int LWIDTH = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                free,
  input  logic [AWIDTH-1:0]   in_addr,
  input  logic [LWIDTH/8-1:0] in_mask,
  input  logic [LWIDTH-1:0]   in_data,
  output logic                full,
  output logic [AWIDTH-1:0]   q_addr,
  output logic [LWIDTH/8-1:0] q_mask,
  output logic [LWIDTH-1:0]   q_data,
  output logic                ovf
);
  // a pulse landing on the grant cycle is a fresh request, not an overflow
  assign ovf = start && full && !free;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full   <= 1'b0;
      q_addr <= '0;
      q_mask <= '0;
      q_data <= '0;
    end else if (start && !ovf) begin
      full   <= 1'b1;
      q_addr <= in_addr;
      q_mask <= in_mask;
      q_data <= in_data;
    end else if (free) begin
      full <= 1'b0;
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one memory request channel between I-cache refill and D-cache refill/writeback
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int LWIDTH     = 128,
  parameter int STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                icr_start_rq,
  input  logic [AWIDTH-1:0]   ic_rin_addr,
  input  logic                dcr_start_rq,
  input  logic [AWIDTH-1:0]   dcr_rin_addr,
  input  logic                dcw_start_rq,
  input  logic [AWIDTH-1:0]   dcw_in_addr,
  input  logic [LWIDTH/8-1:0] dcw_in_mask,
  input  logic [LWIDTH-1:0]   dcw_in_data,
  output logic                rqfull_1,
  output logic [LWIDTH-1:0]   ic_rdat_m_data,
  output logic                ic_rdat_m_valid,
  output logic                ic_finish_mrd,
  output logic [LWIDTH-1:0]   rdat_m_data,
  output logic                rdat_m_valid,
  output logic                finish_mrd,
  output logic                dcw_finish_wresp,
  output logic                mem_rq_valid,
  input  logic                mem_rq_ready,
  output logic                mem_rq_we,
  output logic [AWIDTH-1:0]   mem_rq_addr,
  output logic [LWIDTH/8-1:0] mem_rq_mask,
  output logic [LWIDTH-1:0]   mem_rq_wdata,
  input  logic [LWIDTH-1:0]   mem_rdat_data,
  input  logic                mem_rdat_valid,
  input  logic                mem_finish_rd,
  input  logic                mem_finish_wr,
  output logic                ovf_err
);
  localparam int MW = LWIDTH / 8;
  state_t state, state_n;
  owner_t own, sel;
  logic go, ic_force, ic_gnt, dr_gnt, dw_gnt;
  logic ic_full, dr_full, dw_full, ic_ovf, dr_ovf, dw_ovf;
  logic [AWIDTH-1:0] ic_addr, dr_addr, dw_addr, req_addr;
  logic [MW-1:0] ic_mask, dr_mask, dw_mask, req_mask;
  logic [LWIDTH-1:0] ic_data, dr_data, dw_data, req_wdata;
  logic req_we;
  logic [STARVE_W-1:0] starve_cnt;
  mem_arb_slot #(.AWIDTH(AWIDTH), .LWIDTH(LWIDTH)) u_ic (
    .clk(clk), .rst(rst), .start(icr_start_rq), .free(ic_gnt), .in_addr(ic_rin_addr),
    .in_mask('0), .in_data('0), .full(ic_full), .q_addr(ic_addr), .q_mask(ic_mask),
    .q_data(ic_data), .ovf(ic_ovf));
  mem_arb_slot #(.AWIDTH(AWIDTH), .LWIDTH(LWIDTH)) u_dr (
    .clk(clk), .rst(rst), .start(dcr_start_rq), .free(dr_gnt), .in_addr(dcr_rin_addr),
    .in_mask('0), .in_data('0), .full(dr_full), .q_addr(dr_addr), .q_mask(dr_mask),
    .q_data(dr_data), .ovf(dr_ovf));
  mem_arb_slot #(.AWIDTH(AWIDTH), .LWIDTH(LWIDTH)) u_dw (
    .clk(clk), .rst(rst), .start(dcw_start_rq), .free(dw_gnt), .in_addr(dcw_in_addr),
    .in_mask(dcw_in_mask), .in_data(dcw_in_data), .full(dw_full), .q_addr(dw_addr),
    .q_mask(dw_mask), .q_data(dw_data), .ovf(dw_ovf));
  // writeback beats refill so an evicted line lands before it is re-fetched
  assign ic_force = ic_full && starve_cnt == STARVE_W'(STARVE_MAX);
  always_comb begin
    sel = ic_force ? OWN_IC : dw_full ? OWN_DW : dr_full ? OWN_DR : OWN_IC;
    go = state == IDLE && (ic_full || dr_full || dw_full);
    ic_gnt = go && sel == OWN_IC;
    dr_gnt = go && sel == OWN_DR;
    dw_gnt = go && sel == OWN_DW;
    state_n = state == IDLE    ? (go ? ISSUE : IDLE) :
              state == ISSUE   ? (mem_rq_ready ? (req_we ? WAIT_WR : WAIT_RD) : ISSUE) :
              state == WAIT_RD ? (mem_finish_rd ? IDLE : WAIT_RD) :
                                 (mem_finish_wr ? IDLE : WAIT_WR);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      own        <= OWN_IC;
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_mask   <= '0;
      req_wdata  <= '0;
      starve_cnt <= '0;
      ovf_err    <= 1'b0;
    end else begin
      state   <= state_n;
      ovf_err <= ovf_err | ic_ovf | dr_ovf | dw_ovf;
      if (go) begin
        own       <= sel;
        req_we    <= sel == OWN_DW;
        req_addr  <= sel == OWN_DW ? dw_addr : sel == OWN_DR ? dr_addr : ic_addr;
        req_mask  <= sel == OWN_DW ? dw_mask : sel == OWN_DR ? dr_mask : ic_mask;
        req_wdata <= sel == OWN_DW ? dw_data : sel == OWN_DR ? dr_data : ic_data;
      end
      if (ic_gnt) starve_cnt <= '0;
      else if (state == IDLE && ic_full && !ic_force) starve_cnt <= starve_cnt + 1'b1;
    end
  assign rqfull_1         = dr_full || dw_full;
  assign mem_rq_valid     = state == ISSUE;
  assign mem_rq_we        = mem_rq_valid && req_we;
  assign mem_rq_addr      = req_addr;
  assign mem_rq_mask      = req_mask;
  assign mem_rq_wdata     = req_wdata;
  assign ic_rdat_m_valid  = state == WAIT_RD && own == OWN_IC && mem_rdat_valid;
  assign rdat_m_valid     = state == WAIT_RD && own == OWN_DR && mem_rdat_valid;
  assign ic_rdat_m_data   = ic_rdat_m_valid ? mem_rdat_data : '0;
  assign rdat_m_data      = rdat_m_valid ? mem_rdat_data : '0;
  assign ic_finish_mrd    = state == WAIT_RD && own == OWN_IC && mem_finish_rd;
  assign finish_mrd       = state == WAIT_RD && own == OWN_DR && mem_finish_rd;
  assign dcw_finish_wresp = state == WAIT_WR && mem_finish_wr;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: scenario tasks plus a request scoreboard checked at every accepted memory request
module tb_mem_req_arbiter;
  typedef struct packed {
    logic         we;
    logic [31:0]  addr;
    logic [15:0]  mask;
    logic [127:0] data;
  } req_t;
  logic clk = 0, rst = 1;
  logic icr_start_rq = 0, dcr_start_rq = 0, dcw_start_rq = 0;
  logic [31:0] ic_rin_addr = 0, dcr_rin_addr = 0, dcw_in_addr = 0;
  logic [15:0] dcw_in_mask = 0;
  logic [127:0] dcw_in_data = 0;
  logic rqfull_1, ic_rdat_m_valid, ic_finish_mrd, rdat_m_valid, finish_mrd, dcw_finish_wresp;
  logic [127:0] ic_rdat_m_data, rdat_m_data;
  logic mem_rq_valid, mem_rq_we, ovf_err;
  logic mem_rq_ready = 0;
  logic [31:0] mem_rq_addr;
  logic [15:0] mem_rq_mask;
  logic [127:0] mem_rq_wdata;
  logic [127:0] mem_rdat_data = 0;
  logic mem_rdat_valid = 0, mem_finish_rd = 0, mem_finish_wr = 0;
  int vec = 0, err = 0;
  req_t exp_q[$];
  req_t e;

  mem_req_arbiter dut (
    .clk(clk), .rst(rst),
    .icr_start_rq(icr_start_rq), .ic_rin_addr(ic_rin_addr),
    .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr),
    .dcw_start_rq(dcw_start_rq), .dcw_in_addr(dcw_in_addr),
    .dcw_in_mask(dcw_in_mask), .dcw_in_data(dcw_in_data),
    .rqfull_1(rqfull_1),
    .ic_rdat_m_data(ic_rdat_m_data), .ic_rdat_m_valid(ic_rdat_m_valid), .ic_finish_mrd(ic_finish_mrd),
    .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
    .dcw_finish_wresp(dcw_finish_wresp),
    .mem_rq_valid(mem_rq_valid), .mem_rq_ready(mem_rq_ready), .mem_rq_we(mem_rq_we),
    .mem_rq_addr(mem_rq_addr), .mem_rq_mask(mem_rq_mask), .mem_rq_wdata(mem_rq_wdata),
    .mem_rdat_data(mem_rdat_data), .mem_rdat_valid(mem_rdat_valid),
    .mem_finish_rd(mem_finish_rd), .mem_finish_wr(mem_finish_wr),
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && mem_rq_valid && mem_rq_ready) begin
      vec++;
      if (exp_q.size() == 0) begin
        err++;
        $display("FAIL req_unexpected: got we=%0b addr=%h, required no request", mem_rq_we, mem_rq_addr);
      end else begin
        e = exp_q.pop_front();
        if ({mem_rq_we, mem_rq_addr, mem_rq_mask, mem_rq_wdata} !== e) begin
          err++;
          $display("FAIL req_fields: got we=%0b addr=%h mask=%h data=%h, required we=%0b addr=%h mask=%h data=%h",
                   mem_rq_we, mem_rq_addr, mem_rq_mask, mem_rq_wdata, e.we, e.addr, e.mask, e.data);
        end
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [440:0] all_outs();
    return {rqfull_1, ic_rdat_m_data, ic_rdat_m_valid, ic_finish_mrd, rdat_m_data, rdat_m_valid,
            finish_mrd, dcw_finish_wresp, mem_rq_valid, mem_rq_we, mem_rq_addr, mem_rq_mask,
            mem_rq_wdata, ovf_err};
  endfunction

  task automatic test_reset();
    rst = 1;
    tick();
    tick();
    vec++;
    if (all_outs() !== '0) begin err++; $display("FAIL reset_outputs: got %h, required 0", all_outs()); end
    rst = 0;
    tick();
  endtask

  task automatic test_write();
    dcw_start_rq = 1; dcw_in_addr = 32'h0000_1000; dcw_in_mask = 16'hFFFF;
    dcw_in_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    exp_q.push_back('{1'b1, 32'h0000_1000, 16'hFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210});
    tick();
    dcw_start_rq = 0;
    vec++;
    if ({rqfull_1, mem_rq_valid} !== 2'b10) begin err++; $display("FAIL wr_capture: got rqfull/valid=%b, required 10", {rqfull_1, mem_rq_valid}); end
    tick();
    for (int i = 0; i < 3; i++) begin
      vec++;
      if ({rqfull_1, mem_rq_valid, mem_rq_we} !== 3'b011) begin
        err++; $display("FAIL wr_hold%0d: got rqfull/valid/we=%b, required 011", i, {rqfull_1, mem_rq_valid, mem_rq_we});
      end
      if (i < 2) tick();
    end
    mem_rq_ready = 1;
    tick();
    mem_rq_ready = 0;
    vec++;
    if (mem_rq_valid !== 1'b0) begin err++; $display("FAIL wr_accepted: got valid=%b, required 0", mem_rq_valid); end
    mem_finish_wr = 1;
    #1;
    vec++;
    if (dcw_finish_wresp !== 1'b1) begin err++; $display("FAIL wr_resp: got %b, required 1", dcw_finish_wresp); end
    tick();
    vec++;
    if (dcw_finish_wresp !== 1'b0) begin err++; $display("FAIL wr_resp_once: got %b, required 0", dcw_finish_wresp); end
    mem_finish_wr = 0;
    tick();
  endtask

  task automatic test_wr_rd_order();
    dcw_start_rq = 1; dcw_in_addr = 32'h2000; dcw_in_mask = 16'h00F0; dcw_in_data = 128'hAA55;
    dcr_start_rq = 1; dcr_rin_addr = 32'h3000;
    exp_q.push_back('{1'b1, 32'h2000, 16'h00F0, 128'hAA55});
    exp_q.push_back('{1'b0, 32'h3000, 16'h0, 128'h0});
    tick();
    dcw_start_rq = 0; dcr_start_rq = 0;
    tick();
    vec++;
    if ({mem_rq_valid, mem_rq_we} !== 2'b11) begin err++; $display("FAIL order_wr_first: got valid/we=%b, required 11", {mem_rq_valid, mem_rq_we}); end
    mem_rq_ready = 1;
    tick();
    mem_rq_ready = 0; mem_finish_wr = 1;
    tick();
    mem_finish_wr = 0;
    vec++;
    if (mem_rq_valid !== 1'b0) begin err++; $display("FAIL order_gap: got valid=%b, required 0", mem_rq_valid); end
    tick();
    vec++;
    if ({mem_rq_valid, mem_rq_we} !== 2'b10) begin err++; $display("FAIL order_rd_issue: got valid/we=%b, required 10", {mem_rq_valid, mem_rq_we}); end
    mem_rq_ready = 1;
    tick();
    mem_rq_ready = 0;
    for (int i = 0; i < 4; i++) begin
      mem_rdat_valid = 1; mem_rdat_data = 128'h1000 + 128'(i);
      #1;
      vec++;
      if ({rdat_m_valid, rdat_m_data, ic_rdat_m_valid, ic_rdat_m_data} !== {1'b1, 128'h1000 + 128'(i), 1'b0, 128'h0}) begin
        err++; $display("FAIL rd_beat%0d: got dv=%b dd=%h iv=%b id=%h, required dv=1 dd=%h iv=0 id=0",
                        i, rdat_m_valid, rdat_m_data, ic_rdat_m_valid, ic_rdat_m_data, 128'h1000 + 128'(i));
      end
      tick();
    end
    mem_rdat_valid = 0; mem_finish_rd = 1;
    #1;
    vec++;
    if ({finish_mrd, ic_finish_mrd} !== 2'b10) begin err++; $display("FAIL rd_finish: got d/i=%b, required 10", {finish_mrd, ic_finish_mrd}); end
    tick();
    mem_finish_rd = 0;
    #1;
    vec++;
    if (finish_mrd !== 1'b0) begin err++; $display("FAIL rd_finish_once: got %b, required 0", finish_mrd); end
    tick();
  endtask

  task automatic test_starve();
    int k = 0, ic_fin = 0, cyc = 0;
    mem_rq_ready = 1; mem_finish_rd = 1; mem_finish_wr = 1;
    icr_start_rq = 1; ic_rin_addr = 32'hA000;
    while (cyc < 300 && !(k == 9 && exp_q.size() == 0)) begin
      dcr_start_rq = (k < 9) && !rqfull_1;
      if (dcr_start_rq) begin
        dcr_rin_addr = 32'h4000 + 32'(k * 16);
        exp_q.push_back('{1'b0, 32'h4000 + 32'(k * 16), 16'h0, 128'h0});
        k++;
        if (k == 8) exp_q.push_back('{1'b0, 32'hA000, 16'h0, 128'h0});
      end
      #1;
      if (ic_finish_mrd) ic_fin++;
      tick();
      icr_start_rq = 0;
      cyc++;
    end
    dcr_start_rq = 0;
    for (int i = 0; i < 4; i++) begin
      if (ic_finish_mrd) ic_fin++;
      tick();
    end
    mem_rq_ready = 0; mem_finish_rd = 0; mem_finish_wr = 0;
    tick();
    vec++;
    if (exp_q.size() != 0) begin err++; $display("FAIL starve_drain: got %0d pending, required 0", exp_q.size()); end
    vec++;
    if (ic_fin != 1) begin err++; $display("FAIL starve_ic_finish: got %0d pulses, required 1", ic_fin); end
    vec++;
    if (ovf_err !== 1'b0) begin err++; $display("FAIL starve_no_ovf: got %b, required 0", ovf_err); end
  endtask

  task automatic test_ovf();
    dcr_start_rq = 1; dcr_rin_addr = 32'hC000;
    exp_q.push_back('{1'b0, 32'hC000, 16'h0, 128'h0});
    tick();
    dcr_start_rq = 0;
    tick();
    icr_start_rq = 1; ic_rin_addr = 32'hB000;
    exp_q.push_back('{1'b0, 32'hB000, 16'h0, 128'h0});
    tick();
    icr_start_rq = 0;
    vec++;
    if (ovf_err !== 1'b0) begin err++; $display("FAIL ovf_premature: got %b, required 0", ovf_err); end
    icr_start_rq = 1; ic_rin_addr = 32'hB010;
    tick();
    icr_start_rq = 0;
    vec++;
    if (ovf_err !== 1'b1) begin err++; $display("FAIL ovf_set: got %b, required 1", ovf_err); end
    for (int t = 0; t < 2; t++) begin
      mem_rq_ready = 1;
      tick();
      mem_rq_ready = 0; mem_finish_rd = 1;
      tick();
      mem_finish_rd = 0;
      tick();
    end
    mem_rq_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    mem_rq_ready = 0;
    vec++;
    if ({ovf_err, mem_rq_valid} !== 2'b10) begin err++; $display("FAIL ovf_sticky: got ovf/valid=%b, required 10", {ovf_err, mem_rq_valid}); end
  endtask

  task automatic test_reset_mid();
    icr_start_rq = 1; ic_rin_addr = 32'hD000;
    exp_q.push_back('{1'b0, 32'hD000, 16'h0, 128'h0});
    tick();
    icr_start_rq = 0;
    tick();
    mem_rq_ready = 1;
    tick();
    mem_rq_ready = 0; mem_rdat_valid = 1; mem_rdat_data = 128'hBEEF;
    #1;
    vec++;
    if ({ic_rdat_m_valid, ic_rdat_m_data} !== {1'b1, 128'hBEEF}) begin
      err++; $display("FAIL rstmid_beat: got v=%b d=%h, required v=1 d=beef", ic_rdat_m_valid, ic_rdat_m_data);
    end
    tick();
    rst = 1;
    #1;
    vec++;
    if (all_outs() !== '0) begin err++; $display("FAIL rstmid_clear: got %h, required 0", all_outs()); end
    tick();
    rst = 0; mem_finish_rd = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if ({ic_rdat_m_valid, rdat_m_valid, ic_finish_mrd, finish_mrd, mem_rq_valid} !== 5'b0) begin
        err++; $display("FAIL rstmid_ignore%0d: got %b, required 00000", i,
                        {ic_rdat_m_valid, rdat_m_valid, ic_finish_mrd, finish_mrd, mem_rq_valid});
      end
    end
    mem_rdat_valid = 0; mem_finish_rd = 0;
  endtask

  task automatic test_stray();
    mem_rdat_valid = 1; mem_rdat_data = 128'hFACE; mem_finish_rd = 1; mem_finish_wr = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++;
      if ({ic_rdat_m_valid, ic_rdat_m_data, ic_finish_mrd, rdat_m_valid, rdat_m_data, finish_mrd, dcw_finish_wresp} !== '0) begin
        err++; $display("FAIL stray%0d: got iv=%b dv=%b if=%b df=%b wr=%b, required all 0", i,
                        ic_rdat_m_valid, rdat_m_valid, ic_finish_mrd, finish_mrd, dcw_finish_wresp);
      end
      tick();
    end
    mem_rdat_valid = 0; mem_finish_rd = 0; mem_finish_wr = 0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_wr_rd_order();
    test_starve();
    test_ovf();
    test_reset_mid();
    test_stray();
    vec++;
    if (exp_q.size() != 0) begin err++; $display("FAIL scoreboard_empty: got %0d pending, required 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single external memory request channel between the I-cache refill path (icr_start_rq) and the D-cache writeback/refill paths (dcw_start_rq, dcr_start_rq).
- Latches the one-cycle start pulses and grants one transaction at a time. Routes read data and completion strobes back to the owning cache.
- Sits between cpu_top cache ports and the DDR/AXI bridge.

Parameters:
AWIDTH, 32, request address width
LWIDTH, 128, cache line data width
STARVE_MAX, 8, cycles a pending I-cache request may be bypassed before it is forced to top priority

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
icr_start_rq  in  1  I-cache refill request pulse
ic_rin_addr  in  AWIDTH  I-cache refill address
dcr_start_rq  in  1  D-cache refill request pulse
dcr_rin_addr  in  AWIDTH  D-cache refill address
dcw_start_rq  in  1  D-cache writeback request pulse
dcw_in_addr  in  AWIDTH  writeback address
dcw_in_mask  in  LWIDTH/8  writeback byte mask
dcw_in_data  in  LWIDTH  writeback data
rqfull_1  out  1  D-cache request slot occupied
ic_rdat_m_data  out  LWIDTH  read data to I-cache
ic_rdat_m_valid  out  1  read beat valid to I-cache
ic_finish_mrd  out  1  I-cache refill done
rdat_m_data  out  LWIDTH  read data to D-cache
rdat_m_valid  out  1  read beat valid to D-cache
finish_mrd  out  1  D-cache refill done
dcw_finish_wresp  out  1  writeback done
mem_rq_valid  out  1  request to memory
mem_rq_ready  in  1  memory accepts request
mem_rq_we  out  1  1 = write, 0 = read
mem_rq_addr  out  AWIDTH  request address
mem_rq_mask  out  LWIDTH/8  write mask
mem_rq_wdata  out  LWIDTH  write data
mem_rdat_data  in  LWIDTH  memory read data
mem_rdat_valid  in  1  memory read beat valid
mem_finish_rd  in  1  memory read complete
mem_finish_wr  in  1  memory write response
ovf_err  out  1  sticky: pulse arrived while that slot was pending

Behaviour:
- Pending slots:
  - Three 1-deep slots (IC, DR, DW) capture the address, mask and data on the start pulse.
  - A pulse into an already-full slot is dropped and sets ovf_err. ovf_err clears only on rst.
  - A pulse that arrives in the same cycle its slot is being granted is a new request. The slot stays full.
- rqfull_1 = DR slot full OR DW slot full. It is registered as the value after the slot update.
- Priority, evaluated in IDLE:
  - Normal order is DW > DR > IC. Writeback goes before refill so a line being evicted reaches memory before it is re-fetched.
  - starve_cnt increments on each IDLE cycle where the IC slot is full and not granted. It saturates at STARVE_MAX.
  - When starve_cnt == STARVE_MAX, IC wins. starve_cnt clears on IC grant.
- FSM states:
  - IDLE: a slot is full -> ISSUE. The owner is latched and that slot is freed.
  - ISSUE: mem_rq_valid=1 with fields from the latched request; hold until mem_rq_ready. On ready: we -> WAIT_WR, else -> WAIT_RD.
  - WAIT_RD: each mem_rdat_valid is forwarded combinationally to the owner's data/valid pair; the other pair stays 0. mem_finish_rd -> one-cycle ic_finish_mrd or finish_mrd -> IDLE.
  - WAIT_WR: mem_finish_wr -> one-cycle dcw_finish_wresp -> IDLE.
- Latency:
  - Start pulse to mem_rq_valid is 2 cycles minimum (capture, IDLE, ISSUE).
  - Finish to next mem_rq_valid is 2 cycles.
- Stray inputs: mem_rdat_valid or finish strobes outside their WAIT state are ignored.
- Reset values: all outputs 0, all slots empty, FSM IDLE, starve_cnt 0.
- Reset mid-transaction clears all state. Memory responses still in flight after reset are ignored because the FSM is in IDLE.

Decomposition:
- Package mem_arb_pkg holds:
  - the owner encoding (OWN_IC=0, OWN_DR=1, OWN_DW=2)
  - the FSM state encoding (IDLE/ISSUE/WAIT_RD/WAIT_WR)
  - the STARVE counter width
- One natural sub-module, mem_arb_slot: a 1-deep request holding register with capture/free/overflow. It is instantiated three times; the IC and DR instances tie mask and data to 0.

Test Plan:
- DW write, addr=0x0000_1000, mask=0xFFFF, mem_rq_ready held 3 cycles -> mem_rq_we=1 stays stable for those 3 cycles; mem_finish_wr -> dcw_finish_wresp high exactly 1 cycle; rqfull_1 is 1 from the cycle after the pulse until the grant.
- dcw_start_rq and dcr_start_rq in the same cycle, addr 0x2000/0x3000 -> the write is issued first and the read is issued 2 cycles after mem_finish_wr; read beats appear only on rdat_m_*, and ic_rdat_m_valid stays 0.
- IC pending while the D-cache re-requests continuously with zero-latency memory -> the IC grant occurs no later than the 9th IDLE evaluation (STARVE_MAX=8); ic_finish_mrd pulses once.
- Second icr_start_rq while the IC slot is full -> ovf_err=1 and stays 1; only one IC memory read is issued.
- rst asserted during WAIT_RD after 1 of 4 beats -> outputs go to 0 immediately; later mem_rdat_valid and mem_finish_rd produce no rdat or finish pulses.
- mem_rdat_valid pulsed in IDLE -> no response output toggles.
